// File: rtl/som_ram_responder_if.sv
// RAM-port and dump-stream bundle for som_ram_responder.
// The initiator drives the master side and the responder is the slave.
interface som_ram_responder_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = 24
);
  logic                 OE;
  logic                 WE;
  logic [17:0]          A;
  logic [DATA_W-1:0]    D;
  logic [DATA_W-1:0]    Q;
  logic                 done;
  logic                 busy;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [ADDR_BITS-1:0] dump_addr;
  logic [DATA_W-1:0]    dump_data;
  logic                 dump_last;

  modport master (
    output OE, WE, A, D, done, dump_ready,
    input  Q, busy, dump_valid, dump_addr, dump_data, dump_last
  );

  modport slave (
    input  OE, WE, A, D, done, dump_ready,
    output Q, busy, dump_valid, dump_addr, dump_data, dump_last
  );
endinterface

// File: rtl/som_ram_responder.sv
// RAM responder: serves initiator reads/writes, then streams the whole memory out on done.
// Optional SOM_RAM_RESP_WRCNT_EN adds a saturating wr_cnt of accepted SERVE-state writes.
module som_ram_responder #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = 24
) (
  input logic              clk,
  input logic              rst,
  som_ram_responder_if.slave bus
`ifdef SOM_RAM_RESP_WRCNT_EN
  ,
  output logic [17:0]      wr_cnt
`endif
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {SERVE, DUMP, FIN} state_t;

  state_t               state, state_nxt;
  logic [DATA_W-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic [ADDR_BITS-1:0] ptr;
  logic                 serve_wr;
  logic                 serve_rd;
  logic                 xfer;
  logic                 load;
  logic                 unused_a;

  // Upper address bits alias onto the same word.
  assign idx      = bus.A[ADDR_BITS-1:0];
  assign unused_a = ^bus.A[17:ADDR_BITS];
  assign serve_wr = (state == SERVE) && bus.WE;
  assign serve_rd = (state == SERVE) && bus.OE;
  assign xfer     = bus.dump_valid && bus.dump_ready;
  // Fetch the next word on the prefetch cycle or behind every non-final transfer.
  assign load     = (state == DUMP) && (!bus.dump_valid || (xfer && !bus.dump_last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SERVE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    case (state)
      SERVE: if (bus.done) state_nxt = DUMP;
      DUMP: begin
        bus.busy = 1'b1;
        if (xfer && bus.dump_last) state_nxt = FIN;
      end
      FIN:     if (!bus.done) state_nxt = SERVE;
      default: state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (serve_wr) mem[idx] <= bus.D;
  end

  // Read-before-write: Q takes the old word when OE and WE hit the same index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          bus.Q <= '0;
    else if (serve_rd) bus.Q <= mem[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr            <= '0;
      bus.dump_valid <= 1'b0;
      bus.dump_last  <= 1'b0;
      bus.dump_addr  <= '0;
      bus.dump_data  <= '0;
    end else if (state != DUMP) begin
      ptr            <= '0;
      bus.dump_valid <= 1'b0;
      bus.dump_last  <= 1'b0;
    end else if (load) begin
      bus.dump_data  <= mem[ptr];
      bus.dump_addr  <= ptr;
      bus.dump_last  <= (ptr == {ADDR_BITS{1'b1}});
      bus.dump_valid <= 1'b1;
      ptr            <= ptr + 1'b1;
    end else if (xfer) begin
      bus.dump_valid <= 1'b0;
      bus.dump_last  <= 1'b0;
    end
  end

`ifdef SOM_RAM_RESP_WRCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               wr_cnt <= '0;
    else if (serve_wr && wr_cnt != 18'h3FFFF) wr_cnt <= wr_cnt + 18'd1;
  end
`endif
endmodule

// File: tb/tb_som_ram_responder.sv
// Scoreboard bench for som_ram_responder: serve reads/writes, aliasing, RBW, dump, stall, reset abort.
module tb_som_ram_responder;
  logic clk;
  logic rst;
  logic [23:0] model_mem [256];
  logic [23:0] q_exp [$];
  int          dump_q [$];
  int          checks;
  int          failures;
  int          wr_model;
  logic [23:0] last_q;

  som_ram_responder_if #(.ADDR_BITS(8), .DATA_W(24)) bus ();

`ifdef SOM_RAM_RESP_WRCNT_EN
  logic [17:0] wr_cnt;
  som_ram_responder #(.ADDR_BITS(8), .DATA_W(24)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .wr_cnt(wr_cnt));
`else
  som_ram_responder #(.ADDR_BITS(8), .DATA_W(24)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [17:0] a, input logic [23:0] d);
    @(negedge clk);
    bus.WE = 1'b1; bus.A = a; bus.D = d;
    model_mem[a[7:0]] = d;
    wr_model++;
    @(negedge clk);
    bus.WE = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [17:0] a);
    logic [23:0] e;
    @(negedge clk);
    bus.OE = 1'b1; bus.A = a;
    q_exp.push_back(model_mem[a[7:0]]);
    @(negedge clk);
    bus.OE = 1'b0;
    e = q_exp.pop_front();
    check(tag, bus.Q, e);
    last_q = e;
  endtask

  task automatic do_rw(input string tag, input logic [17:0] a, input logic [23:0] d);
    logic [23:0] e;
    @(negedge clk);
    bus.OE = 1'b1; bus.WE = 1'b1; bus.A = a; bus.D = d;
    q_exp.push_back(model_mem[a[7:0]]);
    model_mem[a[7:0]] = d;
    wr_model++;
    @(negedge clk);
    bus.OE = 1'b0; bus.WE = 1'b0;
    e = q_exp.pop_front();
    check(tag, bus.Q, e);
    last_q = e;
  endtask

  initial begin
    int  e;
    int  stalls;
    bit  got_last;
    bit  seen;
    checks = 0; failures = 0; wr_model = 0; last_q = '0;
    rst = 1'b0;
    bus.OE = 1'b0; bus.WE = 1'b0; bus.A = '0; bus.D = '0;
    bus.done = 1'b0; bus.dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_Q", bus.Q, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.dump_valid, 0);
    check("rst_last", bus.dump_last, 0);
    check("rst_addr", bus.dump_addr, 0);
    check("rst_data", bus.dump_data, 0);
`ifdef SOM_RAM_RESP_WRCNT_EN
    check("rst_wrcnt", wr_cnt, 0);
`endif
    rst = 1'b1;

    do_write(18'd5, 24'hABCDEF);
    do_read("rd_5", 18'd5);
    do_write(18'h00103, 24'h000111);
    do_read("rd_alias", 18'h00003);
    do_write(18'd7, 24'h000007);
    do_rw("rbw_old", 18'd7, 24'h123456);
    do_read("rbw_new", 18'd7);
    @(negedge clk);
    bus.A = 18'd5;
    @(negedge clk);
    check("oe0_hold", bus.Q, last_q);

    for (int i = 0; i < 256; i++) do_write(18'(i), 24'(i));

    // Dump 1: full stream with ready held high and ignored accesses.
    for (int i = 0; i < 256; i++) dump_q.push_back(i);
    @(negedge clk);
    bus.done = 1'b1; bus.dump_ready = 1'b1;
    @(negedge clk);
    check("dump_busy", bus.busy, 1);
    check("dump_prefetch", bus.dump_valid, 0);
    bus.OE = 1'b1; bus.WE = 1'b1; bus.A = 18'd0; bus.D = 24'hFFFFFF;
    got_last = 1'b0; seen = 1'b0;
    for (int c = 0; c < 300 && !got_last; c++) begin
      @(negedge clk);
      if (c == 2) begin bus.OE = 1'b0; bus.WE = 1'b0; end
      if (seen) check("dump_b2b", bus.dump_valid, 1);
      if (bus.dump_valid) begin
        seen = 1'b1;
        if (dump_q.size() > 0) e = dump_q.pop_front(); else e = -1;
        check("dump_data", bus.dump_data, e);
        check("dump_addr", bus.dump_addr, e);
        check("dump_last", bus.dump_last, (e == 255) ? 1 : 0);
        if (bus.dump_last) got_last = 1'b1;
      end
    end
    bus.OE = 1'b0; bus.WE = 1'b0;
    if (!got_last) check("dump_timeout", 0, 1);
    check("dump_all_sent", dump_q.size(), 0);
    @(negedge clk);
    check("fin_valid", bus.dump_valid, 0);
    check("fin_busy", bus.busy, 0);
    check("dump_q_held", bus.Q, last_q);
    bus.done = 1'b0;
    @(negedge clk);
    do_read("serve_after_fin", 18'd0);
`ifdef SOM_RAM_RESP_WRCNT_EN
    check("wrcnt", wr_cnt, wr_model);
`endif

    // Dump 2: stall at index 4, then reset while word 10 is presented.
    dump_q.delete();
    for (int i = 0; i < 256; i++) dump_q.push_back(i);
    @(negedge clk);
    bus.done = 1'b1; bus.dump_ready = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    stalls = 0; got_last = 1'b0;
    for (int c = 0; c < 100 && !got_last; c++) begin
      @(negedge clk);
      if (bus.dump_valid) begin
        e = (dump_q.size() > 0) ? dump_q[0] : -1;
        check("stall_data", bus.dump_data, e);
        check("stall_addr", bus.dump_addr, e);
        check("stall_last", bus.dump_last, 0);
        if (e == 4 && stalls < 3) begin
          bus.dump_ready = 1'b0;
          stalls++;
        end else if (e == 10) begin
          got_last = 1'b1;
        end else begin
          bus.dump_ready = 1'b1;
          void'(dump_q.pop_front());
        end
      end
    end
    if (!got_last) check("abort_timeout", 0, 1);
    check("stall_count", stalls, 3);
    #2 rst = 1'b0;
    #1;
    check("abort_valid", bus.dump_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_data", bus.dump_data, 0);
    repeat (2) @(negedge clk);
`ifdef SOM_RAM_RESP_WRCNT_EN
    check("abort_wrcnt", wr_cnt, 0);
`endif
    rst = 1'b1;
    bus.dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("post_abort_busy", bus.busy, 0);
    check("post_abort_valid", bus.dump_valid, 0);
    do_read("mem_kept", 18'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/som_ram_responder.md
SOM_RAM_RESPONDER -- requirements
Module: som_ram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8, sets the number of storage index bits; DEPTH = 2^ADDR_BITS words.
REQ-002 Parameter DATA_W, default 24, sets the word width; all data ports use this width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 resets the block immediately, independent of clk.
REQ-005 OE  input  1  read enable from the RAM-port initiator.
REQ-006 WE  input  1  write enable from the RAM-port initiator.
REQ-007 A  input  18  word address from the initiator.
REQ-008 D  input  DATA_W  write data from the initiator.
REQ-009 Q  output  DATA_W  registered read data returned to the initiator.
REQ-010 done  input  1  initiator completion flag; starts the dump sequence.
REQ-011 busy  output  1  high while in DUMP; initiator accesses are ignored.
REQ-012 dump_valid  output  1  dump word available.
REQ-013 dump_ready  input  1  downstream accepts the dump word.
REQ-014 dump_addr  output  ADDR_BITS  index of the current dump word.
REQ-015 dump_data  output  DATA_W  contents of the word at dump_addr.
REQ-016 dump_last  output  1  high with dump_valid on index DEPTH-1.

Function
REQ-017 The FSM states shall be SERVE (reset state), DUMP and FIN.
REQ-018 Storage index shall be A[ADDR_BITS-1:0]; upper address bits are ignored, so addresses alias modulo DEPTH.
REQ-019 In SERVE, WE=1 at a clock edge shall write D to mem[index].
REQ-020 In SERVE, OE=1 at a clock edge shall load Q with mem[index] (read latency 1 cycle); OE=0 holds Q.
REQ-021 In SERVE, if OE=1 and WE=1 at the same index, Q shall return the pre-write (old) word and the memory shall take D.
REQ-022 In SERVE, done=1 at a clock edge shall move to DUMP with the dump pointer set to 0; any OE/WE in that same cycle is still serviced.
REQ-023 In DUMP, OE and WE shall be ignored and Q held; busy=1.
REQ-024 dump_valid shall assert on the second cycle in DUMP (one prefetch cycle), with dump_data = mem[dump_addr].
REQ-025 dump_data, dump_addr and dump_last shall remain stable while dump_valid=1 and dump_ready=0.
REQ-026 A transfer occurs on dump_valid & dump_ready; the next word shall be valid on the following cycle (back-to-back throughput of 1 word/cycle).
REQ-027 The transfer with dump_last=1 shall move to FIN; dump_valid shall be 0 in FIN.
REQ-028 FIN shall return to SERVE on the first edge with done=0; FIN shall ignore OE/WE.

Reset
REQ-029 On rst=0: state=SERVE, Q=0, busy=0, dump_valid=0, dump_last=0, dump_addr=0, dump_data=0, dump pointer=0.
REQ-030 Memory contents shall not be reset; they are undefined until written.
REQ-031 Reset asserted mid-DUMP shall abort the dump with no further transfer; after release the block is in SERVE.

Configuration
REQ-032 Macro SOM_RAM_RESP_WRCNT_EN: when defined, an output port wr_cnt [17:0] shall exist and count accepted SERVE-state writes, saturating at 262143 and reset to 0 by rst.
REQ-033 Without SOM_RAM_RESP_WRCNT_EN, the wr_cnt port and its counter shall be absent; all other behaviour is identical.

Verification
REQ-034 Write D=0xABCDEF at A=5, then OE at A=5 -> Q=0xABCDEF one cycle after the read edge.
REQ-035 With ADDR_BITS=8: write 0x000111 at A=0x00103, read at A=0x00003 -> Q=0x000111 (aliasing).
REQ-036 Preload A=7 with 0x000007, then OE=WE=1 at A=7 with D=0x123456 -> Q=0x000007; a subsequent read returns 0x123456.
REQ-037 Fill mem[i]=i, pulse done, dump_ready=1 -> 256 consecutive words 0..255, dump_last only on 255, then FIN; done=0 -> SERVE.
REQ-038 During DUMP hold dump_ready=0 for 3 cycles at dump_addr=4 -> dump_data stays 4; also apply rst=0 mid-dump -> dump_valid=0 immediately.
REQ-039 With SOM_RAM_RESP_WRCNT_EN defined, 10 writes in SERVE plus 3 WE pulses during DUMP -> wr_cnt=10.
